exu_muldiv_stage: RTL

//  Iterative RV32M/RV64M multiply/divide execute unit. Sits beside the single-cycle EXU ALU.

---
 rtl/exu_muldiv_stage_pkg.sv | 37 +++
 rtl/exu_muldiv_stage_iter_core.sv | 55 +++++
 rtl/exu_muldiv_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/exu_muldiv_stage_pkg.sv
// Shared opcode encodings, FSM state type and operand-class helpers for the mul/div unit.
// IDU decode imports the same encodings so both sides agree.
package exu_muldiv_stage_pkg;

  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StCalc = 2'd1,
    StFix  = 2'd2,
    StDone = 2'd3
  } md_state_e;

  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_is_rem(input logic [2:0] op);
    return op[2] & op[1];
  endfunction

  function automatic logic md_a_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
  endfunction

  function automatic logic md_b_signed(input logic [2:0] op);
    return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
  endfunction

endpackage

// File: rtl/exu_muldiv_stage_iter_core.sv
// Iteration datapath: 2*XLEN accumulator plus multiplicand/divisor register.
// One shift-add (multiply) or restoring-subtract (divide) step per i_step.
module muldiv_iter_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic              i_step,
  input  logic              i_is_div,
  input  logic [XLEN-1:0]   i_a,
  input  logic [XLEN-1:0]   i_b,
  output logic [2*XLEN-1:0] o_acc
);

  logic [2*XLEN-1:0] r_acc;
  logic [XLEN-1:0]   r_opnd;
  logic [XLEN:0]     w_mul_sum;
  logic [XLEN:0]     w_div_part;
  logic [XLEN:0]     w_div_trial;
  logic [2*XLEN-1:0] w_acc_step;

  // Multiply: {hi, multiplier} shifts right, adding the multiplicand into hi on a set lsb.
  // Divide: {rem, dividend} shifts left, quotient bits enter at the lsb.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                  (r_acc[0] ? {1'b0, r_opnd} : {(XLEN+1){1'b0}});
    w_div_part  = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
    w_div_trial = w_div_part - {1'b0, r_opnd};
    if (i_is_div) begin
      if (w_div_trial[XLEN]) begin
        w_acc_step = {w_div_part[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};
      end else begin
        w_acc_step = {w_div_trial[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
      end
    end else begin
      w_acc_step = {w_mul_sum, r_acc[XLEN-1:1]};
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_acc  <= '0;
      r_opnd <= '0;
    end else if (i_load) begin
      r_acc  <= {{XLEN{1'b0}}, i_a};
      r_opnd <= i_b;
    end else if (i_step) begin
      r_acc  <= w_acc_step;
    end
  end

  assign o_acc = r_acc;

endmodule

// File: rtl/exu_muldiv_stage.sv
// Iterative RV M-extension execute unit: FSM, special-case detection, sign fix and
// valid/ready handshakes around the muldiv_iter_core datapath.
module exu_muldiv_stage
  import exu_muldiv_stage_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             i_clock,
  input  logic             i_reset_n,
  input  logic             i_flush,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [2:0]       i_in_op,
  input  logic [XLEN-1:0]  i_in_a,
  input  logic [XLEN-1:0]  i_in_b,
  input  logic [TAG_W-1:0] i_in_tag,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [XLEN-1:0]  o_out_result,
  output logic [TAG_W-1:0] o_out_tag,
  output logic             o_busy
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;

  md_state_e         r_state;
  md_state_e         w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_op;
  logic              r_neg;
  logic [TAG_W-1:0]  r_tag_pend;
  logic [TAG_W-1:0]  r_out_tag;
  logic [XLEN-1:0]   r_result;

  logic              w_accept;
  logic              w_load;
  logic              w_step;
  logic              w_a_neg;
  logic              w_b_neg;
  logic              w_neg;
  logic [XLEN-1:0]   w_a_mag;
  logic [XLEN-1:0]   w_b_mag;
  logic [XLEN-1:0]   w_min;
  logic              w_b_zero;
  logic              w_ovf;
  logic              w_special;
  logic [XLEN-1:0]   w_special_res;
  logic [2*XLEN-1:0] w_acc;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_div_sel;
  logic [XLEN-1:0]   w_fix_res;

  assign w_accept = (r_state == StIdle) & i_in_valid & ~i_flush;

  always_comb begin
    w_min         = {1'b1, {(XLEN-1){1'b0}}};
    w_a_neg       = md_a_signed(i_in_op) & i_in_a[XLEN-1];
    w_b_neg       = md_b_signed(i_in_op) & i_in_b[XLEN-1];
    w_a_mag       = w_a_neg ? -i_in_a : i_in_a;
    w_b_mag       = w_b_neg ? -i_in_b : i_in_b;
    // Remainder follows the dividend; everything else follows the sign product.
    w_neg         = md_is_rem(i_in_op) ? w_a_neg : (w_a_neg ^ w_b_neg);
    w_b_zero      = (i_in_b == '0);
    w_ovf         = ((i_in_op == MD_DIV) || (i_in_op == MD_REM)) &&
                    (i_in_a == w_min) && (i_in_b == '1);
    w_special     = md_is_div(i_in_op) & (w_b_zero | w_ovf);
    if (w_b_zero) begin
      w_special_res = md_is_rem(i_in_op) ? i_in_a : '1;
    end else begin
      w_special_res = md_is_rem(i_in_op) ? '0 : w_min;
    end
  end

  always_comb begin
    w_prod    = r_neg ? -w_acc : w_acc;
    w_div_sel = md_is_rem(r_op) ? w_acc[2*XLEN-1:XLEN] : w_acc[XLEN-1:0];
    if (md_is_div(r_op)) begin
      w_fix_res = r_neg ? -w_div_sel : w_div_sel;
    end else if (r_op == MD_MUL) begin
      w_fix_res = w_prod[XLEN-1:0];
    end else begin
      w_fix_res = w_prod[2*XLEN-1:XLEN];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          w_state_next = w_special ? StDone : StCalc;
          w_load       = ~w_special;
        end
      end
      StCalc: begin
        w_step = 1'b1;
        if (r_cnt == CNT_W'(XLEN - 1)) begin
          w_state_next = StFix;
        end
      end
      StFix:   w_state_next = StDone;
      StDone: begin
        if (i_out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
    if (i_flush) begin
      w_state_next = StIdle;
    end
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_op       <= MD_MUL;
      r_neg      <= 1'b0;
      r_tag_pend <= '0;
      r_out_tag  <= '0;
      r_result   <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op       <= i_in_op;
        r_neg      <= w_neg;
        r_tag_pend <= i_in_tag;
        r_cnt      <= '0;
        if (w_special) begin
          r_result  <= w_special_res;
          r_out_tag <= i_in_tag;
        end
      end
      if (r_state == StCalc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if ((r_state == StFix) && !i_flush) begin
        r_result  <= w_fix_res;
        r_out_tag <= r_tag_pend;
      end
    end
  end

  muldiv_iter_core #(
    .XLEN (XLEN)
  ) u_core (
    .i_clock   (i_clock),
    .i_reset_n (i_reset_n),
    .i_load    (w_load),
    .i_step    (w_step),
    .i_is_div  (md_is_div(r_op)),
    .i_a       (w_a_mag),
    .i_b       (w_b_mag),
    .o_acc     (w_acc)
  );

  assign o_in_ready   = (r_state == StIdle) & i_reset_n;
  assign o_out_valid  = (r_state == StDone);
  assign o_busy       = (r_state != StIdle);
  assign o_out_result = r_result;
  assign o_out_tag    = r_out_tag;

endmodule
